apd_gate_counter: RTL

APD_GATE_COUNTER -- requirements
Module: apd_gate_counter

---
 rtl/apd_cnt_pkg.sv | 21 ++
 rtl/apd_channel.sv | 128 ++++++++++++
 rtl/apd_gate_counter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/apd_cnt_pkg.sv
//------------------------------------------------------------------------------
// apd_cnt_pkg
// Shared constants and types for the two-channel APD gate counter:
//   CNT_W    default width of every accumulator and latched count
//   NUM_CH   number of APD channels
//   CNT_SAT  saturation value for the default width
//   hold_state_e  per-channel dead-time state encoding (IDLE / HOLD)
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package apd_cnt_pkg;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned NUM_CH = 2;
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } hold_state_e;

endpackage

// File: rtl/apd_channel.sv
//------------------------------------------------------------------------------
// apd_channel
// One APD input path: synchronizer, rising-edge detect, dead-time hold-off
// and a saturating running event accumulator with a sticky overflow bit.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   sclr_acc        clears the running accumulator and overflow bit only
//   en_acc          acquisition gate; accepted events count only while high
//   apd_in          raw asynchronous pulse input
//   dead_time       hold-off length in clk cycles, sampled on each acceptance
//   accept          high in the cycle a detect is accepted (decoded from
//                   registered state only)
//   count, overflow running accumulator and sticky saturation flag
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module apd_channel #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = apd_cnt_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclr_acc,
  input  logic             en_acc,
  input  logic             apd_in,
  input  logic [7:0]       dead_time,
  output logic             accept,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);
  import apd_cnt_pkg::*;

  localparam logic [CNT_W-1:0] SAT_V = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE_V = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   edge_r;
  logic                   detect_r;
  hold_state_e            state_r;
  hold_state_e            state_s;
  logic [7:0]             hold_cnt_r;
  logic [7:0]             hold_cnt_s;
  logic                   accept_s;
  logic [CNT_W-1:0]       count_r;
  logic                   overflow_r;

  // Synchronizer chain plus registered edge detect; detect_r is one flop past
  // the edge compare so the input-to-detect latency is SYNC_STAGES+1 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r   <= {SYNC_STAGES{1'b0}};
      edge_r   <= 1'b0;
      detect_r <= 1'b0;
    end else begin
      sync_r   <= {sync_r[SYNC_STAGES-2:0], apd_in};
      edge_r   <= sync_r[SYNC_STAGES-1];
      detect_r <= sync_r[SYNC_STAGES-1] & ~edge_r;
    end
  end

  // Dead-time state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
    end
  end

  // Dead-time next state: HOLD ignores detects for exactly dead_time cycles,
  // using the value captured at acceptance.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    accept_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (detect_r) begin
          accept_s = 1'b1;
          if (dead_time != 8'd0) begin
            state_s    = ST_HOLD;
            hold_cnt_s = dead_time - 8'd1;
          end else begin
            state_s    = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_r == 8'd0) begin
          state_s = ST_IDLE;
        end else begin
          hold_cnt_s = hold_cnt_r - 8'd1;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        hold_cnt_s = 8'd0;
      end
    endcase
  end

  // Saturating running accumulator; clear beats a same-cycle increment and
  // overflow latches once the count reaches full scale.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else if (sclr_acc) begin
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else if (accept_s && en_acc) begin
      if (count_r != SAT_V) begin
        count_r <= count_r + ONE_V;
      end
      if (count_r >= (SAT_V - ONE_V)) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign accept   = accept_s;
  assign count    = count_r;
  assign overflow = overflow_r;

endmodule

// File: rtl/apd_gate_counter.sv
//------------------------------------------------------------------------------
// apd_gate_counter
// Two-channel gated APD photon counter with coincidence and gate-length
// accumulators and a latch/clear interface.
// Ports:
//   clk, rst        100 MHz system clock, synchronous active-high reset
//   apd_in[1:0]     raw asynchronous pulses, bit n = channel n
//   en_acc          acquisition gate
//   sclr_acc        clears running accumulators and running overflow bits
//   en_acc_ctrl     copies pre-edge running values to the outputs
//   dead_time       per-channel hold-off after an accepted event (cycles)
//   count0, count1  latched per-channel event counts
//   coinc           latched same-cycle coincidence count
//   gate_cycles     latched count of cycles with en_acc high
//   overflow[1:0]   latched per-channel saturation flags
//   latched_valid   high in the cycle the new latched values appear
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module apd_gate_counter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = apd_cnt_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       apd_in,
  input  logic             en_acc,
  input  logic             sclr_acc,
  input  logic             en_acc_ctrl,
  input  logic [7:0]       dead_time,
  output logic [CNT_W-1:0] count0,
  output logic [CNT_W-1:0] count1,
  output logic [CNT_W-1:0] coinc,
  output logic [CNT_W-1:0] gate_cycles,
  output logic [1:0]       overflow,
  output logic             latched_valid
);
  import apd_cnt_pkg::*;

  localparam logic [CNT_W-1:0] SAT_V = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE_V = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NUM_CH-1:0] accept_s;
  logic [NUM_CH-1:0] run_ovf_s;
  logic [CNT_W-1:0]  run0_s;
  logic [CNT_W-1:0]  run1_s;
  logic [CNT_W-1:0]  coinc_run_r;
  logic [CNT_W-1:0]  gate_run_r;
  logic [CNT_W-1:0]  count0_r;
  logic [CNT_W-1:0]  count1_r;
  logic [CNT_W-1:0]  coinc_r;
  logic [CNT_W-1:0]  gate_r;
  logic [1:0]        overflow_r;
  logic              valid_r;

  apd_channel #(
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W)
  ) u_ch0 (
    .clk       (clk),
    .rst       (rst),
    .sclr_acc  (sclr_acc),
    .en_acc    (en_acc),
    .apd_in    (apd_in[0]),
    .dead_time (dead_time),
    .accept    (accept_s[0]),
    .count     (run0_s),
    .overflow  (run_ovf_s[0])
  );

  apd_channel #(
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W)
  ) u_ch1 (
    .clk       (clk),
    .rst       (rst),
    .sclr_acc  (sclr_acc),
    .en_acc    (en_acc),
    .apd_in    (apd_in[1]),
    .dead_time (dead_time),
    .accept    (accept_s[1]),
    .count     (run1_s),
    .overflow  (run_ovf_s[1])
  );

  // Running coincidence and gate-length accumulators, saturating.
  always_ff @(posedge clk) begin
    if (rst || sclr_acc) begin
      coinc_run_r <= {CNT_W{1'b0}};
      gate_run_r  <= {CNT_W{1'b0}};
    end else if (en_acc) begin
      if (gate_run_r != SAT_V) begin
        gate_run_r <= gate_run_r + ONE_V;
      end
      if ((&accept_s) && (coinc_run_r != SAT_V)) begin
        coinc_run_r <= coinc_run_r + ONE_V;
      end
    end
  end

  // Output latch: samples the pre-edge running values, so a same-cycle
  // increment or clear never leaks into (or out of) the latched snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      count0_r   <= {CNT_W{1'b0}};
      count1_r   <= {CNT_W{1'b0}};
      coinc_r    <= {CNT_W{1'b0}};
      gate_r     <= {CNT_W{1'b0}};
      overflow_r <= 2'b00;
      valid_r    <= 1'b0;
    end else begin
      valid_r <= en_acc_ctrl;
      if (en_acc_ctrl) begin
        count0_r   <= run0_s;
        count1_r   <= run1_s;
        coinc_r    <= coinc_run_r;
        gate_r     <= gate_run_r;
        overflow_r <= run_ovf_s;
      end
    end
  end

  assign count0        = count0_r;
  assign count1        = count1_r;
  assign coinc         = coinc_r;
  assign gate_cycles   = gate_r;
  assign overflow      = overflow_r;
  assign latched_valid = valid_r;

endmodule
